// File: rtl/toggle_handshake_rx.sv
// Purpose : receive side of a toggle req/ack CDC handshake; presents the word on valid/ready.
// Latency : req_tgl flip -> out_valid in SYNC_STAGES+1 clk edges; accept -> ack_tgl flip on the same edge.
// Backpres: out_valid/out_data held until out_ready; the ack is withheld, so tx stalls on backpressure.
//
// Ports:
//   clk        receive-domain clock (posedge)
//   RST        asynchronous active-high reset
//   CLR        synchronous active-high clear (drops any pending word, realigns ack to req)
//   req_tgl    request toggle from the foreign tx domain
//   req_data   payload, held stable by tx from the req_tgl flip until it sees the ack
//   ack_tgl    registered acknowledge toggle back to tx
//   out_valid  out_data holds an unaccepted word
//   out_data   captured payload, stable while out_valid=1
//   out_ready  consumer accept (effective only while out_valid=1)
//   busy       FSM is not IDLE
//   overrun, overrun_cnt  (only with HSRX_OVERRUN_EN) sticky flag / saturating count of
//                         req_tgl changes seen while a word is still in flight
//
// Optional feature macro: HSRX_OVERRUN_EN
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              CLR,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
`ifdef HSRX_OVERRUN_EN
  ,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VALID   = 2'd1,
    ACKWAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              ack_nxt;

  // Synchroniser for the request toggle; bit 0 is the first (metastable) flop.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   pending;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  // A new request exists whenever the synchronised request parity differs from our ack.
  assign pending = req_s ^ ack_tgl;
  assign busy    = (state != IDLE);

  // Next-state / next-output logic.
  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    ack_nxt       = ack_tgl;

    if (CLR) begin
      // Realign ack to the current request parity so nothing looks pending afterwards.
      state_nxt     = IDLE;
      out_valid_nxt = 1'b0;
      ack_nxt       = req_s;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            // req_data is stable here because tx holds it until it sees our ack.
            out_data_nxt  = req_data;
            out_valid_nxt = 1'b1;
            state_nxt     = VALID;
          end
        end
        VALID: begin
          if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
            ack_nxt       = ~ack_tgl;
            state_nxt     = ACKWAIT;
          end
        end
        ACKWAIT: begin
          // One settling cycle before the parity compare is trusted again.
          state_nxt = IDLE;
        end
        default: begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      ack_tgl   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      ack_tgl   <= ack_nxt;
    end
  end

`ifdef HSRX_OVERRUN_EN
  // req_s is about to change on this edge when the flop before it disagrees with it.
  logic req_s_change;
  assign req_s_change = sync_q[SYNC_STAGES-2] ^ req_s;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (CLR) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (req_s_change && (state != IDLE)) begin
      overrun <= 1'b1;
      if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_toggle_handshake_rx.sv
module tb_toggle_handshake_rx;

  logic       clk = 1'b0;
  logic       RST;
  logic       CLR;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
`ifdef HSRX_OVERRUN_EN
  logic       overrun;
  logic [7:0] overrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ack;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .RST       (RST),
    .CLR       (CLR),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef HSRX_OVERRUN_EN
    ,
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for out_valid; a timeout shows up as a failed comparison.
  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CLR = 1'b0; req_tgl = 1'b0; req_data = 8'h00; out_ready = 1'b0;

    // 1: reset values
    tick(); tick();
    chk("rst_ack",   {31'd0, ack_tgl},   32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'h00);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    RST = 1'b0;
    tick();

    // 2: single word, consumer always ready
    req_data = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
    tick(); chk("t2_edge1_valid", {31'd0, out_valid}, 32'd0);
    tick(); chk("t2_edge2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t2_edge3_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_edge3_data",  {24'd0, out_data},  32'hA5);
    chk("t2_edge3_ack",   {31'd0, ack_tgl},   32'd0);
    chk("t2_edge3_busy",  {31'd0, busy},      32'd1);
    tick();
    chk("t2_accept_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_accept_ack",   {31'd0, ack_tgl},   32'd1);
    chk("t2_ackwait_busy", {31'd0, busy},      32'd1);
    tick();
    chk("t2_idle_busy",  {31'd0, busy},      32'd0);
    chk("t2_idle_valid", {31'd0, out_valid}, 32'd0);

    // 3: backpressure for 10 cycles; out_data must not follow req_data
    out_ready = 1'b0; req_data = 8'h3C; req_tgl = 1'b0;
    tick(); tick(); tick();
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_data",  {24'd0, out_data},  32'h3C);
    req_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_data",  {24'd0, out_data},  32'h3C);
      chk("t3_hold_ack",   {31'd0, ack_tgl},   32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_accept_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_accept_ack",   {31'd0, ack_tgl},   32'd0);
    out_ready = 1'b0;
    tick();
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // 4: stream 0x01..0x10, tx flips only after seeing each ack
    exp_ack = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      req_data = i[7:0];
      req_tgl  = ~req_tgl;
      wait_valid("t4");
      chk("t4_data", {24'd0, out_data}, i);
      tick();
      exp_ack = ~exp_ack;
      chk("t4_ack",         {31'd0, ack_tgl},   {31'd0, exp_ack});
      chk("t4_valid_after", {31'd0, out_valid}, 32'd0);
    end
    chk("t4_ack_final", {31'd0, ack_tgl}, 32'd0);
    out_ready = 1'b0;
    tick(); tick();

    // 5: CLR while a word is waiting in VALID
    req_data = 8'h77; req_tgl = 1'b1;
    wait_valid("t5");
    chk("t5_data", {24'd0, out_data}, 32'h77);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("t5_clr_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_clr_busy",  {31'd0, busy},      32'd0);
    chk("t5_clr_ack",   {31'd0, ack_tgl},   32'd1);
    chk("t5_clr_data",  {24'd0, out_data},  32'h77);
    out_ready = 1'b1;   // ready with nothing valid must be ignored
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_spurious", {31'd0, out_valid}, 32'd0);
    end
    chk("t5_ack_stable", {31'd0, ack_tgl}, 32'd1);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of VALID
    req_data = 8'h5A; req_tgl = 1'b0;
    wait_valid("t6rst");
    chk("trst_data", {24'd0, out_data}, 32'h5A);
    #2;
    RST = 1'b1;
    #1;
    chk("trst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("trst_async_ack",   {31'd0, ack_tgl},   32'd0);
    chk("trst_async_data",  {24'd0, out_data},  32'h00);
    chk("trst_async_busy",  {31'd0, busy},      32'd0);
    tick();
    RST = 1'b0;
    tick(); tick(); tick(); tick();
    chk("trst_after_valid", {31'd0, out_valid}, 32'd0);

`ifdef HSRX_OVERRUN_EN
    // 6: two extra flips while VALID
    chk("t6_ovr_init", {31'd0, overrun},    32'd0);
    chk("t6_cnt_init", {24'd0, overrun_cnt}, 32'd0);
    req_data = 8'hC3; req_tgl = 1'b1;
    wait_valid("t6");
    req_tgl = 1'b0;
    tick(); tick(); tick(); tick();
    req_tgl = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_ovr",   {31'd0, overrun},     32'd1);
    chk("t6_cnt",   {24'd0, overrun_cnt}, 32'd2);
    chk("t6_valid", {31'd0, out_valid},   32'd1);
    chk("t6_data",  {24'd0, out_data},    32'hC3);
    out_ready = 1'b1;
    tick();
    chk("t6_ack",          {31'd0, ack_tgl},   32'd1);
    chk("t6_accept_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_lost_word", {31'd0, out_valid}, 32'd0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("t6_clr_ovr", {31'd0, overrun},     32'd0);
    chk("t6_clr_cnt", {24'd0, overrun_cnt}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
